// File: rtl/lmsm_pkg.sv
// Shared types and default sizing for the LM/SM multi-register transfer sequencer.
package lmsm_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} lmsm_state_t;

  localparam int NREGS     = 8;
  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int ADDR_STEP = 2;

endpackage

// File: rtl/lmsm_sequencer_lsb_priority_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit, plus any/exactly-one flags.
module lsb_priority_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any,
  output logic                 last
);

  localparam int IW = $clog2(N);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any  = |vec;
  assign last = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: owns the data-memory port while busy, moving one mask-selected register
// per cycle between consecutive memory words starting at a latched base address.
module lmsm_sequencer #(
  parameter int NREGS     = lmsm_pkg::NREGS,
  parameter int AW        = lmsm_pkg::AW,
  parameter int DW        = lmsm_pkg::DW,
  parameter int ADDR_STEP = lmsm_pkg::ADDR_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     is_sm,
  input  logic [AW-1:0]            base_addr,
  input  logic [NREGS-1:0]         reg_mask,
  input  logic                     flush,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(NREGS)-1:0] rf_raddr,
  input  logic [DW-1:0]            rf_rdata,
  output logic                     rf_we,
  output logic [$clog2(NREGS)-1:0] rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  output logic                     busy,
  output logic                     done
);

  import lmsm_pkg::*;

  localparam int IW = $clog2(NREGS);

  lmsm_state_t      state;
  logic [NREGS-1:0] mask_rem;
  logic [AW-1:0]    cur_addr;
  logic             sm_mode;

  logic [IW-1:0]    enc_idx;
  logic             enc_any;
  logic             enc_last;

  lsb_priority_enc #(
    .N (NREGS)
  ) u_enc (
    .vec  (mask_rem),
    .idx  (enc_idx),
    .any  (enc_any),
    .last (enc_last)
  );

  // Control state: an empty mask still passes through FIN so the requester sees done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mask_rem <= '0;
      cur_addr <= '0;
      sm_mode  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush && start) begin
            mask_rem <= reg_mask;
            cur_addr <= base_addr;
            sm_mode  <= is_sm;
            state    <= (reg_mask != '0) ? S_RUN : S_FIN;
          end
        end
        S_RUN: begin
          mask_rem[enc_idx] <= 1'b0;
          cur_addr          <= cur_addr + AW'(ADDR_STEP);
          if (flush)                    state <= S_IDLE;
          else if (enc_last || !enc_any) state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Port drive: everything is quiet outside RUN; flush only suppresses the done pulse.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_raddr  = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    busy      = (state != S_IDLE);
    done      = (state == S_FIN) && !flush;
    if (state == S_RUN) begin
      mem_addr = cur_addr;
      if (sm_mode) begin
        rf_raddr  = enc_idx;
        mem_wr    = 1'b1;
        mem_wdata = rf_rdata;
      end else begin
        mem_rd   = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = enc_idx;
        rf_wdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: directed and random LM/SM transfers against a transfer-list model.
module tb_lmsm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_sm;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        flush;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic [15:0] rf      [0:7];
  logic [15:0] ref_rf  [0:7];

  lmsm_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_sm     (is_sm),
    .base_addr (base_addr),
    .reg_mask  (reg_mask),
    .flush     (flush),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and register file that the sequencer drives; writes land mid-cycle.
  assign mem_rdata = mem[mem_addr[15:1]];
  assign rf_rdata  = rf[rf_raddr];

  always @(negedge clk) begin
    if (mem_wr) mem[mem_addr[15:1]] = mem_wdata;
    if (rf_we)  rf[rf_waddr] = rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".rd"},   mem_rd, 0);
    check({tag, ".wr"},   mem_wr, 0);
    check({tag, ".we"},   rf_we, 0);
    check({tag, ".addr"}, mem_addr, 0);
    check({tag, ".ports"}, {rf_raddr, rf_waddr, rf_wdata, mem_wdata}, 0);
  endtask

  // One transaction: the model lists the k-th set bit -> base + 2k and walks the cycles.
  task automatic run_txn(input string tag, input logic sm, input logic [15:0] base,
                         input logic [7:0] mask, input int flush_at, input int restart_at,
                         input int reset_at);
    int          regs[$];
    logic [15:0] addrs[$];
    int          n;
    int          last_c;
    int          r;
    logic [15:0] a;
    logic        idle_c, run_c, fin_c, exp_rd, exp_wr;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        addrs.push_back(base + 16'(2 * regs.size()));
        regs.push_back(i);
      end
    end
    n = regs.size();
    last_c = n + 2;
    if (flush_at > 0) last_c = flush_at + 1;
    if (reset_at > 0) last_c = reset_at;

    start = 1'b1; is_sm = sm; base_addr = base; reg_mask = mask; flush = 1'b0;
    #1;
    check({tag, ".c0_busy"}, busy, 0);
    @(posedge clk); #1;
    for (int c = 1; c <= last_c; c++) begin
      start = (c == restart_at);
      if (c == restart_at) begin
        is_sm = ~sm; base_addr = 16'h3000; reg_mask = 8'h80;
      end
      flush = (c == flush_at);
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet({tag, ".rst"});
        rst_n = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        @(posedge clk); #1;
        break;
      end
      #1;
      idle_c = (flush_at > 0 && c > flush_at) || (c > n + 1);
      run_c  = !idle_c && (c <= n);
      fin_c  = !idle_c && (c == n + 1);
      exp_rd = run_c && !sm;
      exp_wr = run_c && sm;
      a = run_c ? addrs[c-1] : 16'h0;
      r = run_c ? regs[c-1] : 0;
      check($sformatf("%s.c%0d_busy", tag, c), busy, !idle_c);
      check($sformatf("%s.c%0d_done", tag, c), done, fin_c && (c != flush_at));
      check($sformatf("%s.c%0d_rd", tag, c), mem_rd, exp_rd);
      check($sformatf("%s.c%0d_wr", tag, c), mem_wr, exp_wr);
      check($sformatf("%s.c%0d_we", tag, c), rf_we, exp_rd);
      check($sformatf("%s.c%0d_addr", tag, c), mem_addr, a);
      check($sformatf("%s.c%0d_waddr", tag, c), rf_waddr, exp_rd ? r : 0);
      check($sformatf("%s.c%0d_wdata", tag, c), rf_wdata, exp_rd ? ref_mem[a[15:1]] : 16'h0);
      check($sformatf("%s.c%0d_raddr", tag, c), rf_raddr, exp_wr ? r : 0);
      check($sformatf("%s.c%0d_mwdata", tag, c), mem_wdata, exp_wr ? ref_rf[r] : 16'h0);
      if (run_c) begin
        if (sm) ref_mem[a[15:1]] = ref_rf[r];
        else    ref_rf[r] = ref_mem[a[15:1]];
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) check($sformatf("%s.rf%0d", tag, i), rf[i], ref_rf[i]);
    foreach (addrs[i]) check($sformatf("%s.mem%0d", tag, i), mem[addrs[i][15:1]], ref_mem[addrs[i][15:1]]);
  endtask

  initial begin
    logic [7:0]  m;
    logic [15:0] b;
    int          f;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'($urandom);
      ref_rf[i] = rf[i];
    end
    rst_n = 1'b0; start = 1'b0; is_sm = 1'b0; base_addr = '0; reg_mask = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("lm_basic", 1'b0, 16'h0100, 8'b1000_0101, -1, -1, -1);

    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'hA000 + 16'(i);
      ref_rf[i] = rf[i];
    end
    run_txn("sm_all", 1'b1, 16'h0010, 8'hFF, -1, -1, -1);
    for (int i = 0; i < 8; i++) check($sformatf("sm_all.val%0d", i), mem[8 + i], 16'hA000 + 16'(i));

    run_txn("empty", 1'b0, 16'h0200, 8'h00, -1, -1, -1);
    run_txn("wrap", 1'b0, 16'hFFFE, 8'h03, -1, -1, -1);
    run_txn("restart_flush", 1'b1, 16'h0400, 8'h0F, 2, 2, -1);
    run_txn("flush_fin", 1'b0, 16'h0500, 8'h10, 2, -1, -1);
    run_txn("reset_mid", 1'b0, 16'h0600, 8'h0F, -1, -1, 3);
    run_txn("after_rst", 1'b1, 16'h0700, 8'h42, -1, -1, -1);

    start = 1'b1; flush = 1'b1; is_sm = 1'b0; reg_mask = 8'h03; base_addr = 16'h0800;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check_quiet("idle_flush");
    @(posedge clk); #1;

    for (int t = 0; t < 16; t++) begin
      m = 8'($urandom);
      b = 16'($urandom) & 16'hFFFE;
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, $countones(m) + 1)) : -1;
      run_txn($sformatf("rnd%0d", t), 1'($urandom), b, m, f, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
